// File: rtl/bool_led_pkg.sv
// Shared op encoding and per-bit Boolean helpers for the LED ALU.
package bool_led_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_NAND = 3'd1,
      OP_OR   = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5
   } op_t;

   localparam int NUM_OPS = 6;

   // Single-bit evaluation; callers replicate it across any operand width.
   function automatic logic op_apply(input op_t op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_NAND: r = ~(a & b);
         OP_OR:   r = a | b;
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [NUM_OPS-1:0] op_onehot(input op_t op);
      logic [NUM_OPS-1:0] v;
      case (op)
         OP_AND:  v = 6'b100000;
         OP_NAND: v = 6'b010000;
         OP_OR:   v = 6'b001000;
         OP_NOR:  v = 6'b000100;
         OP_XOR:  v = 6'b000010;
         OP_XNOR: v = 6'b000001;
         default: v = 6'b000000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/bool_led_debounce.sv
// Button synchroniser, optional debounce filter and rising-edge step pulse.
// BOOL_LED_DEBOUNCE_EN selects the filtered path; otherwise the synced level is used directly.
module bool_led_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic step
);

   logic sync1_reg;
   logic sync2_reg;

   if (DEB_CYCLES < 2) begin : g_deb_cycles_check
      $error("DEB_CYCLES must be at least 2");
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= btn;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef BOOL_LED_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES);

   logic [CW-1:0] cnt_reg;
   logic          deb_reg;
   logic          deb_prev_reg;

   // Accept a new level only after it has differed from deb for DEB_CYCLES edges in a row.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg      <= '0;
         deb_reg      <= 1'b0;
         deb_prev_reg <= 1'b0;
      end else begin
         deb_prev_reg <= deb_reg;
         if (sync2_reg != deb_reg) begin
            if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
               deb_reg <= sync2_reg;
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign step = deb_reg & ~deb_prev_reg;
`else
   logic sync_prev_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_prev_reg <= 1'b0;
      end else begin
         sync_prev_reg <= sync2_reg;
      end
   end

   assign step = sync2_reg & ~sync_prev_reg;
`endif

endmodule

// File: rtl/bool_led_alu.sv
// Registered six-op bitwise ALU for switch/LED boards with button or auto-timer op select.
// Button debounce is enabled by defining BOOL_LED_DEBOUNCE_EN.
module bool_led_alu
   import bool_led_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DEB_CYCLES  = 16,
   parameter int AUTO_PERIOD = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               btn_next,
   input  logic               auto_en,
   output logic [WIDTH-1:0]   out,
   output logic [NUM_OPS-1:0] op_onehot
);

   localparam int TW = $clog2(AUTO_PERIOD);

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] res_next;
   logic             auto_sync1_reg;
   logic             auto_sync2_reg;
   logic [TW-1:0]    timer_reg;
   op_t              op_reg;
   op_t              op_next;
   logic             step_btn;
   logic             step_auto;
   logic             step;

   bool_led_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_next),
      .step (step_btn)
   );

   assign step_auto = auto_sync2_reg & (timer_reg == TW'(AUTO_PERIOD - 1));
   // OR-ing the sources makes a coincident button and timer step advance only once.
   assign step      = step_btn | step_auto;

   always_comb begin
      op_next = op_reg;
      if (step) begin
         if (op_reg == OP_XNOR) begin
            op_next = OP_AND;
         end else begin
            op_next = op_t'(op_reg + 3'd1);
         end
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign res_next[gi] = op_apply(op_reg, a_reg[gi], b_reg[gi]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg          <= '0;
         b_reg          <= '0;
         out_reg        <= '0;
         auto_sync1_reg <= 1'b0;
         auto_sync2_reg <= 1'b0;
         timer_reg      <= '0;
         op_reg         <= OP_AND;
      end else begin
         a_reg          <= in_a;
         b_reg          <= in_b;
         out_reg        <= res_next;
         auto_sync1_reg <= auto_en;
         auto_sync2_reg <= auto_sync1_reg;
         op_reg         <= op_next;
         if (!auto_sync2_reg || step_auto) begin
            timer_reg <= '0;
         end else begin
            timer_reg <= timer_reg + 1'b1;
         end
      end
   end

   assign out       = out_reg;
   assign op_onehot = bool_led_pkg::op_onehot(op_reg);

endmodule
